// File: rtl/tv_apply_engine.sv
// Test-vector apply engine: streams vectors into the CUT, waits a settle time, compares against gold.
// Define TV_APPLY_MISR_EN to add a MISR signature (misr_sig) over the CUT responses.
module tv_apply_engine #(
    parameter int unsigned VEC_W      = 50,
    parameter int unsigned RESP_W     = 22,
    parameter int unsigned SETTLE_CYC = 6,
    parameter int unsigned IDX_W      = 16
`ifdef TV_APPLY_MISR_EN
    ,
    parameter logic [RESP_W-1:0] MISR_POLY = RESP_W'(32'h200001)
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              vec_valid,
    input  logic [VEC_W-1:0]  vec_data,
    input  logic              vec_last,
    output logic              vec_ready,
    output logic [VEC_W-1:0]  cut_in,
    input  logic [RESP_W-1:0] cut_resp,
    input  logic [RESP_W-1:0] gold_resp,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  vec_cnt,
    output logic [IDX_W-1:0]  fail_cnt,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic              first_fail_valid,
    output logic              pass
`ifdef TV_APPLY_MISR_EN
    ,
    output logic [RESP_W-1:0] misr_sig
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSettle,
        StCompare,
        StDone
    } stateT;

    localparam logic [7:0]       SettleLoad = 8'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0] IdxMax     = '1;

    stateT              stateQ, stateD;
    logic [VEC_W-1:0]   cutInQ, cutInD;
    logic               lastQ, lastD;
    logic [7:0]         settleQ, settleD;
    logic [IDX_W-1:0]   vecCntQ, vecCntD;
    logic [IDX_W-1:0]   failCntQ, failCntD;
    logic [IDX_W-1:0]   ffIdxQ, ffIdxD;
    logic               ffValidQ, ffValidD;
    logic               mismatch;
`ifdef TV_APPLY_MISR_EN
    logic [RESP_W-1:0]  misrQ, misrD;
`endif

    assign mismatch = (cut_resp != gold_resp);

    always_comb begin
        stateD   = stateQ;
        cutInD   = cutInQ;
        lastD    = lastQ;
        settleD  = settleQ;
        vecCntD  = vecCntQ;
        failCntD = failCntQ;
        ffIdxD   = ffIdxQ;
        ffValidD = ffValidQ;
`ifdef TV_APPLY_MISR_EN
        misrD    = misrQ;
`endif
        unique case (stateQ)
            StIdle, StDone: begin
                if (start) begin
                    vecCntD  = '0;
                    failCntD = '0;
                    ffIdxD   = '0;
                    ffValidD = 1'b0;
`ifdef TV_APPLY_MISR_EN
                    misrD    = '0;
`endif
                    stateD   = StFetch;
                end
            end
            StFetch: begin
                if (vec_valid) begin
                    cutInD  = vec_data;
                    lastD   = vec_last;
                    settleD = SettleLoad;
                    stateD  = StSettle;
                end
            end
            StSettle: begin
                if (settleQ == 8'd0) begin
                    stateD = StCompare;
                end else begin
                    settleD = settleQ - 8'd1;
                end
            end
            StCompare: begin
                if (mismatch) begin
                    if (failCntQ != IdxMax) begin
                        failCntD = failCntQ + 1'b1;
                    end
                    if (!ffValidQ) begin
                        ffIdxD   = vecCntQ;
                        ffValidD = 1'b1;
                    end
                end
                if (vecCntQ != IdxMax) begin
                    vecCntD = vecCntQ + 1'b1;
                end
`ifdef TV_APPLY_MISR_EN
                misrD = {misrQ[RESP_W-2:0], 1'b0}
                        ^ (misrQ[RESP_W-1] ? MISR_POLY : '0)
                        ^ cut_resp;
`endif
                stateD = lastQ ? StDone : StFetch;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= StIdle;
            cutInQ   <= '0;
            lastQ    <= 1'b0;
            settleQ  <= '0;
            vecCntQ  <= '0;
            failCntQ <= '0;
            ffIdxQ   <= '0;
            ffValidQ <= 1'b0;
`ifdef TV_APPLY_MISR_EN
            misrQ    <= '0;
`endif
        end else begin
            stateQ   <= stateD;
            cutInQ   <= cutInD;
            lastQ    <= lastD;
            settleQ  <= settleD;
            vecCntQ  <= vecCntD;
            failCntQ <= failCntD;
            ffIdxQ   <= ffIdxD;
            ffValidQ <= ffValidD;
`ifdef TV_APPLY_MISR_EN
            misrQ    <= misrD;
`endif
        end
    end

    assign vec_ready        = (stateQ == StFetch);
    assign busy             = (stateQ == StFetch) || (stateQ == StSettle) || (stateQ == StCompare);
    assign done             = (stateQ == StDone);
    assign pass             = done && (failCntQ == '0);
    assign cut_in           = cutInQ;
    assign vec_cnt          = vecCntQ;
    assign fail_cnt         = failCntQ;
    assign first_fail_idx   = ffIdxQ;
    assign first_fail_valid = ffValidQ;
`ifdef TV_APPLY_MISR_EN
    assign misr_sig         = misrQ;
`endif

endmodule

// File: doc/tv_apply_engine.md
Name: tv_apply_engine

Overview:
- Hardware reader of the kept random test-vector set produced by the fault-coverage generator flow.
- Accepts vectors one at a time over a valid/ready stream from the vector-memory loader.
- For each vector it drives the circuit-under-test inputs, waits a programmable settle time, then compares the CUT response against the golden-model response.
- Reports the vector count, mismatch count and the index of the first failing vector. Sits between the vector-memory loader and the CUT/golden pair in the on-chip test harness.

Parameters:
VEC_W, 50, width of one test vector (CUT primary inputs)
RESP_W, 22, width of the CUT and golden responses (primary outputs)
SETTLE_CYC, 6, clock cycles between driving cut_in and sampling responses; legal range 1..255
IDX_W, 16, width of the vector counter, mismatch counter and fail index

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run when the engine is in IDLE or DONE
vec_valid  in  1  vec_data/vec_last valid
vec_data  in  VEC_W  test vector
vec_last  in  1  marks the final vector of the set
vec_ready  out  1  engine accepts a vector this cycle
cut_in  out  VEC_W  registered stimulus to the CUT and golden model
cut_resp  in  RESP_W  CUT outputs
gold_resp  in  RESP_W  golden-model outputs
busy  out  1  run in progress
done  out  1  run complete; held until the next start or reset
vec_cnt  out  IDX_W  vectors applied in the current run
fail_cnt  out  IDX_W  mismatching vectors in the current run
first_fail_idx  out  IDX_W  0-based index of the first mismatching vector
first_fail_valid  out  1  first_fail_idx holds a captured value
pass  out  1  done && fail_cnt==0

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0: cut_in, counters, first_fail_*, busy, done, pass, vec_ready.
- FSM states: IDLE, FETCH, SETTLE, COMPARE, DONE.
- IDLE / DONE:
  - On start: clear vec_cnt, fail_cnt, first_fail_idx, first_fail_valid and done; go to FETCH.
  - vec_ready=0 in both states.
- FETCH:
  - vec_ready=1.
  - On vec_valid && vec_ready:
    - register vec_data into cut_in;
    - register vec_last into an internal last flag;
    - load the settle counter with SETTLE_CYC-1;
    - go to SETTLE.
  - While vec_valid=0, the engine stays in FETCH and cut_in holds its previous value.
- SETTLE:
  - cut_in is stable. The counter decrements each cycle.
  - When the counter is 0, go to COMPARE, so the engine spends exactly SETTLE_CYC cycles in SETTLE.
- COMPARE (single cycle):
  - Sample cut_resp and gold_resp; a mismatch is any bit difference.
  - On mismatch:
    - fail_cnt increments, saturating at all-ones;
    - if first_fail_valid=0, first_fail_idx takes vec_cnt (value before increment) and first_fail_valid is set.
  - vec_cnt increments, saturating at all-ones.
  - If the last flag is set, go to DONE; otherwise go to FETCH.
- DONE: done=1, busy=0, pass as defined. Counters are frozen.
- busy=1 in FETCH, SETTLE and COMPARE.
- Throughput: SETTLE_CYC+2 cycles per vector when vec_valid is always high.
- start while busy is ignored.
- A vector with vec_last=1 ends the run even if vec_cnt is 0 (single-vector set).
- Reset mid-run aborts immediately. No partial results are retained, and no vector is consumed after reset until the next start.
- vec_ready is asserted only in FETCH, so at most one vector is consumed per handshake. No buffering.

Optional Feature:
- Macro: TV_APPLY_MISR_EN.
- When defined:
  - Adds output port misr_sig (RESP_W bits, reset 0, cleared on start).
  - In each COMPARE cycle: misr_sig <= ({misr_sig[RESP_W-2:0],1'b0} ^ (misr_sig[RESP_W-1] ? MISR_POLY : 0)) ^ cut_resp.
  - Adds parameter MISR_POLY, default 'h200001 (x^22+x^21+1 feedback mask).
- When not defined: no misr_sig port, no MISR_POLY parameter, and no MISR logic.
- All other behaviour is identical with or without the macro.

Test Plan:
1. SETTLE_CYC=6; start, then 3 vectors back-to-back with vec_last on the 3rd, cut_resp==gold_resp -> done rises 24 cycles after the first handshake; vec_cnt=3, fail_cnt=0, pass=1, first_fail_valid=0.
2. 4 vectors; force gold_resp=cut_resp^22'h1 during vectors 1 and 2 -> fail_cnt=2, first_fail_idx=1, first_fail_valid=1, pass=0.
3. Drop vec_valid for 10 cycles after vector 0 -> engine stays in FETCH with vec_ready=1, cut_in holds vector 0 and busy=1; run completes normally once valid returns.
4. Assert rst_n=0 during SETTLE of vector 2 -> all outputs 0 in the same cycle; the state after release is IDLE. A fresh start with 1 vector (vec_last=1) gives vec_cnt=1 and done=1.
5. Pulse start mid-run -> ignored, counters unaffected. Pulse start in DONE -> counters cleared, done=0, a new run begins.
6. TV_APPLY_MISR_EN defined: vector A with cut_resp=22'h000001, then vector B with cut_resp=22'h000000 -> misr_sig=22'h000001 after A and 22'h000002 after B.
